// File: rtl/q1_pkg.sv
// rtl/q1_pkg.sv - shared types and sum/carry evaluation for the registered full adder
package q1_pkg;

    localparam int MAX_LATENCY = 8;

    typedef struct packed {
        logic carry;
        logic sum;
    } fa_out_t;

    function automatic fa_out_t fa_eval(input logic a, input logic b, input logic c);
        fa_out_t r;
        r.sum   = a ^ b ^ c;
        r.carry = (a & b) | (b & c) | (a & c);
        return r;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder core
module fa_cell
    import q1_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    fa_out_t result;

    assign result = fa_eval(a, b, c);
    assign sum    = result.sum;
    assign carry  = result.carry;

endmodule

// File: rtl/q1_full_adder.sv
// rtl/q1_full_adder.sv - full adder followed by a LATENCY-deep registered output pipeline
module q1_full_adder
    import q1_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y0,
    output logic y1
);

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("q1_full_adder: LATENCY must be in 1..%0d", MAX_LATENCY);
    end

    logic    cell_sum;
    logic    cell_carry;
    fa_out_t cell_out;

    fa_cell u_cell (
        .a     (a),
        .b     (b),
        .c     (c),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    assign cell_out.sum   = cell_sum;
    assign cell_out.carry = cell_carry;

    // Stage 0 samples the core; each later stage copies its predecessor every cycle.
    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        fa_out_t q;
        if (i == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else begin
                    q <= cell_out;
                end
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else begin
                    q <= g_stage[i-1].q;
                end
            end
        end
    end

    assign y0 = g_stage[LATENCY-1].q.sum;
    assign y1 = g_stage[LATENCY-1].q.carry;

endmodule

// File: tb/tb_q1_full_adder.sv
// tb/tb_q1_full_adder.sv - randomized and directed checks of q1_full_adder at LATENCY 1 and 3
module tb_q1_full_adder;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic c;
    logic y0_l1;
    logic y1_l1;
    logic y0_l3;
    logic y1_l3;

    int checks;
    int failures;

    // One entry per rising edge: arithmetic result of the sampled inputs,
    // whether reset was high, and whether the inputs were undefined.
    int exp_q[$];
    bit rst_q[$];
    bit dc_q[$];

    q1_full_adder #(.LATENCY(1)) dut_l1 (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .y0  (y0_l1),
        .y1  (y1_l1)
    );

    q1_full_adder #(.LATENCY(3)) dut_l3 (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .y0  (y0_l3),
        .y1  (y1_l3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Output after the latest edge comes from the edge LATENCY-1 earlier,
    // unless any reset edge occurred in between.
    function automatic int model_out(input int lat, output bit ok);
        int k;
        int j;
        k  = exp_q.size() - 1;
        j  = k - lat + 1;
        ok = 1'b1;
        if (j < 0) begin
            ok = 1'b0;
            return 0;
        end
        for (int m = j; m <= k; m++) begin
            if (rst_q[m]) return 0;
        end
        if (dc_q[j]) ok = 1'b0;
        return exp_q[j];
    endfunction

    task automatic step(input string tag, input logic [2:0] code, input bit rst_in, input bit undef);
        int  e;
        bit  ok;
        rst = rst_in;
        if (undef) begin
            a = 1'bz;
            b = 1'bz;
            c = 1'bz;
        end else begin
            a = code[2];
            b = code[1];
            c = code[0];
        end
        @(posedge clk);
        exp_q.push_back(int'(code[2]) + int'(code[1]) + int'(code[0]));
        rst_q.push_back(rst_in);
        dc_q.push_back(undef);
        #1;
        e = model_out(1, ok);
        if (ok) check({tag, "_l1"}, {y1_l1, y0_l1}, e[1:0]);
        e = model_out(3, ok);
        if (ok) check({tag, "_l3"}, {y1_l3, y0_l3}, e[1:0]);
    endtask

    logic [2:0] carry_codes [8];
    logic [2:0] sum_codes [8];

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        a = 1'b0;
        b = 1'b0;
        c = 1'b0;
        carry_codes = '{3'b011, 3'b110, 3'b101, 3'b111, 3'b000, 3'b001, 3'b010, 3'b100};
        sum_codes   = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b000, 3'b011, 3'b101, 3'b110};

        for (int i = 0; i < 3; i++) step("reset_state", 3'b000, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) step("exhaustive", 3'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("carry_group", carry_codes[i], 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("sum_group", sum_codes[i], 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                step("transition_from", 3'(i), 1'b0, 1'b0);
                step("transition_to", 3'(j), 1'b0, 1'b0);
            end
        end

        for (int i = 0; i < 3; i++) step("pre_reset", 3'b111, 1'b0, 1'b0);
        step("mid_reset", 3'b111, 1'b1, 1'b0);
        check("reset_clears_l1", {y1_l1, y0_l1}, 2'b00);
        check("reset_clears_l3", {y1_l3, y0_l3}, 2'b00);
        for (int i = 0; i < 4; i++) step("post_reset", 3'b111, 1'b0, 1'b0);

        step("z_in", 3'b000, 1'b0, 1'b1);
        step("z_flush", 3'b101, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("z_after", 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        check("z_known_l1", {1'b0, $isunknown({y1_l1, y0_l1})}, 2'b00);
        check("z_known_l3", {1'b0, $isunknown({y1_l3, y0_l3})}, 2'b00);

        for (int i = 0; i < 300; i++) begin
            step("random", 3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
